// File: rtl/branch_predictor_gshare.sv
// branch_predictor_gshare: tagged BTB with saturating direction counters, bimodal or gshare indexed
module branch_predictor_gshare #(
  parameter int ADDR_W = 32,
  parameter int INDEX_W = 7,
  parameter int TAG_W = 8,
  parameter int CNT_W = 2,
  parameter int HIST_W = 6,
  localparam int HW = (HIST_W > 0) ? HIST_W : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_fire,
  output logic [ADDR_W-1:0] pred_pc,
  output logic              pred_taken,
  output logic              pred_hit,
  output logic [HW-1:0]     pred_hist,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic              ex_is_jal,
  input  logic              ex_is_jalr,
  input  logic              ex_taken,
  input  logic              ex_mispredict,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic [HW-1:0]     ex_hist,
  output logic [31:0]       perf_branches,
  output logic [31:0]       perf_mispredicts
);
  localparam int N = 1 << INDEX_W;
  localparam logic [CNT_W-1:0] WT = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] WNT = WT - CNT_W'(1);
  logic [N-1:0] valid, uncond;
  logic [TAG_W-1:0] tag [N];
  logic [ADDR_W-1:0] target [N];
  logic [CNT_W-1:0] ctr [N];
  logic [HW-1:0] ghr;
  logic [INDEX_W-1:0] fi, ui;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic act, train, recover, u_hit;
  logic [CNT_W-1:0] ctr_new;
  always_comb begin
    fi = if_pc[INDEX_W+1:2] ^ ((HIST_W > 0) ? INDEX_W'(ghr) : '0);
    ui = ex_pc[INDEX_W+1:2] ^ ((HIST_W > 0) ? INDEX_W'(ex_hist) : '0);
    if_tag = if_pc[INDEX_W+2+TAG_W-1:INDEX_W+2];
    ex_tag = ex_pc[INDEX_W+2+TAG_W-1:INDEX_W+2];
    act = rdy && !rst;
    pred_hit = act && valid[fi] && tag[fi] == if_tag;
    pred_taken = pred_hit && (uncond[fi] || ctr[fi][CNT_W-1]);
    pred_pc = pred_taken ? target[fi] : if_pc + ADDR_W'(4);
    pred_hist = ghr;
    train = ex_valid && (ex_is_branch || ex_is_jal) && !ex_is_jalr;
    recover = ex_valid && ex_is_branch && ex_mispredict;
    u_hit = valid[ui] && tag[ui] == ex_tag;
    ctr_new = !u_hit ? (ex_taken ? WT : WNT) :
              ex_taken ? ((&ctr[ui]) ? ctr[ui] : ctr[ui] + CNT_W'(1)) :
              ((ctr[ui] == '0) ? ctr[ui] : ctr[ui] - CNT_W'(1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < N; i++) ctr[i] <= WNT;
      ghr <= '0;
      perf_branches <= '0;
      perf_mispredicts <= '0;
    end else if (rdy) begin
      if (train) begin
        valid[ui] <= 1'b1;
        tag[ui] <= ex_tag;
        target[ui] <= ex_target;
        uncond[ui] <= ex_is_jal;
        ctr[ui] <= ctr_new;
        if (!(&perf_branches)) perf_branches <= perf_branches + 32'd1;
        if (ex_mispredict && !(&perf_mispredicts)) perf_mispredicts <= perf_mispredicts + 32'd1;
      end
      // recovery overrides the speculative shift when both happen in one cycle
      if (HIST_W > 0 && recover) ghr <= HW'({ex_hist, ex_taken});
      else if (HIST_W > 0 && if_fire && pred_hit && !uncond[fi]) ghr <= HW'({ghr, pred_taken});
    end
  end
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb_branch_predictor_gshare: directed checks on a bimodal and a gshare instance sharing stimulus
module tb_branch_predictor_gshare;
  logic clk = 0, rst = 1, rdy = 1, if_fire = 0;
  logic [31:0] if_pc = 0, ex_pc = 0, ex_target = 0;
  logic ex_valid = 0, ex_is_branch = 0, ex_is_jal = 0, ex_is_jalr = 0, ex_taken = 0, ex_mispredict = 0;
  logic [5:0] ex_hist = 0;
  logic [31:0] pc_b, pc_g, pb_b, pm_b, pb_g, pm_g;
  logic tk_b, tk_g, hit_b, hit_g;
  logic [0:0] hist_b;
  logic [5:0] hist_g;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  branch_predictor_gshare #(.ADDR_W(32), .INDEX_W(7), .TAG_W(8), .CNT_W(2), .HIST_W(0)) dut_b (
    .clk(clk), .rst(rst), .rdy(rdy), .if_pc(if_pc), .if_fire(if_fire),
    .pred_pc(pc_b), .pred_taken(tk_b), .pred_hit(hit_b), .pred_hist(hist_b),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_taken(ex_taken), .ex_mispredict(ex_mispredict), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_hist(ex_hist[0:0]), .perf_branches(pb_b), .perf_mispredicts(pm_b));

  branch_predictor_gshare #(.ADDR_W(32), .INDEX_W(7), .TAG_W(8), .CNT_W(2), .HIST_W(6)) dut_g (
    .clk(clk), .rst(rst), .rdy(rdy), .if_pc(if_pc), .if_fire(if_fire),
    .pred_pc(pc_g), .pred_taken(tk_g), .pred_hit(hit_g), .pred_hist(hist_g),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_taken(ex_taken), .ex_mispredict(ex_mispredict), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_hist(ex_hist), .perf_branches(pb_g), .perf_mispredicts(pm_g));

  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", t, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  // kind: 0 branch, 1 jal, 2 jalr
  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input int kind,
                       input logic tk, input logic mp, input logic [5:0] h);
    ex_pc = pc; ex_target = tgt; ex_taken = tk; ex_mispredict = mp; ex_hist = h;
    ex_is_branch = (kind == 0); ex_is_jal = (kind == 1); ex_is_jalr = (kind == 2);
    ex_valid = 1;
    tick();
    ex_valid = 0; ex_mispredict = 0; ex_hist = 0;
  endtask

  initial begin
    tick(); tick();
    rst = 0;
    look(32'h100);
    chk("reset_taken", {31'b0, tk_b}, 0);
    chk("reset_pc", pc_b, 32'h104);
    chk("reset_hit", {31'b0, hit_b}, 0);
    chk("reset_perf_b", pb_b, 0);
    chk("reset_perf_m", pm_g, 0);
    chk("reset_hist_g", {26'b0, hist_g}, 0);
    // bimodal counter walk: 10,11,10,01,00,01
    train(32'h100, 32'h80, 0, 1, 0, 0); look(32'h100);
    chk("bim_t1_pc", pc_b, 32'h80);
    chk("bim_t1_hit", {31'b0, hit_b}, 1);
    train(32'h100, 32'h80, 0, 1, 0, 0); look(32'h100);
    chk("bim_t2_pc", pc_b, 32'h80);
    train(32'h100, 32'h80, 0, 0, 0, 0); look(32'h100);
    chk("bim_n1_pc", pc_b, 32'h80);
    train(32'h100, 32'h80, 0, 0, 0, 0); look(32'h100);
    chk("bim_n2_pc", pc_b, 32'h104);
    chk("bim_n2_hit", {31'b0, hit_b}, 1);
    train(32'h100, 32'h80, 0, 0, 0, 0); look(32'h100);
    chk("bim_n3_pc", pc_b, 32'h104);
    train(32'h100, 32'h80, 0, 1, 0, 0); look(32'h100);
    chk("bim_clamp_pc", pc_b, 32'h104);
    chk("perf_after_bim", pb_b, 6);
    // jal predicts regardless of counter; jalr never installs
    train(32'h200, 32'h400, 1, 1, 0, 0); look(32'h200);
    chk("jal_pc", pc_b, 32'h400);
    train(32'h200, 32'h400, 1, 0, 0, 0); look(32'h200);
    chk("jal_ctr_ignored", {31'b0, tk_b}, 1);
    train(32'h300, 32'h700, 2, 1, 0, 0); look(32'h300);
    chk("jalr_no_hit", {31'b0, hit_b}, 0);
    chk("jalr_no_perf", pb_b, 8);
    // 0x300 aliases 0x100 with a different tag
    train(32'h300, 32'h500, 0, 1, 0, 0); look(32'h100);
    chk("alias_evict_hit", {31'b0, hit_b}, 0);
    chk("alias_evict_pc", pc_b, 32'h104);
    look(32'h300);
    chk("alias_new_pc", pc_b, 32'h500);
    // rdy low: outputs masked, nothing changes
    rdy = 0; if_fire = 1;
    ex_pc = 32'h100; ex_target = 32'h80; ex_is_branch = 1; ex_is_jal = 0; ex_is_jalr = 0;
    ex_taken = 1; ex_mispredict = 1; ex_hist = 6'h2A; ex_valid = 1;
    look(32'h300);
    chk("rdy0_hit", {31'b0, hit_g}, 0);
    chk("rdy0_pc", pc_b, 32'h304);
    tick();
    ex_valid = 0; ex_mispredict = 0; ex_hist = 0; if_fire = 0; rdy = 1;
    look(32'h100);
    chk("rdy0_no_train", {31'b0, hit_b}, 0);
    chk("rdy0_ghr", {26'b0, hist_g}, 0);
    chk("rdy0_perf", pb_g, 9);
    chk("rdy0_perf_m", pm_g, 0);
    // gshare history recovery and speculation
    train(32'h1000, 32'h40, 0, 1, 1, 6'b000001);
    chk("rec_ghr3", {26'b0, hist_g}, 32'h03);
    chk("bim_hist", {31'b0, hist_b}, 0);
    train(32'h300, 32'h600, 0, 1, 0, 6'b000011); look(32'h300);
    chk("gsh_pred_pc", pc_g, 32'h600);
    chk("gsh_pred_hist", {26'b0, hist_g}, 32'h03);
    if_fire = 1;
    train(32'h2000, 32'h44, 0, 0, 1, 6'b101010);
    if_fire = 0;
    chk("rec_wins", {26'b0, hist_g}, 32'h14);
    train(32'h1000, 32'h40, 0, 1, 1, 6'b000001);
    chk("rec_ghr3b", {26'b0, hist_g}, 32'h03);
    look(32'h300);
    if_fire = 1;
    tick();
    if_fire = 0;
    chk("spec_shift", {26'b0, hist_g}, 32'h07);
    chk("perf_b_cnt", pb_b, 13);
    chk("perf_m_cnt", pm_g, 3);
    // saturation from a preloaded value
    dut_g.perf_branches = 32'hFFFF_FFFE;
    dut_g.perf_mispredicts = 32'hFFFF_FFFF;
    train(32'h200, 32'h400, 1, 1, 1, 0);
    chk("sat_b_1", pb_g, 32'hFFFF_FFFF);
    train(32'h200, 32'h400, 1, 1, 1, 0);
    chk("sat_b_2", pb_g, 32'hFFFF_FFFF);
    chk("sat_m", pm_g, 32'hFFFF_FFFF);
    // mid-operation reset
    rst = 1;
    look(32'h200);
    chk("rst_mask_hit", {31'b0, hit_g}, 0);
    chk("rst_mask_pc", pc_b, 32'h204);
    tick();
    rst = 0;
    look(32'h200);
    chk("post_rst_hit", {31'b0, hit_b}, 0);
    chk("post_rst_perf", pb_g, 0);
    chk("post_rst_ghr", {26'b0, hist_g}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
